// File: rtl/lc3b_types.sv
// Shared LC-3b types plus the BTB entry record and tag-match helper.
// Used by branch_target_buffer (optional BTB_STATS_EN counters live in the top).
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    // Tag is held at its widest size (index_bits >= 0), zero-extended.
    localparam int unsigned BTB_TAG_W = 15;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        lc3b_word             target;
    } btb_entry_t;

    function automatic logic btb_tag_match(input logic valid, input logic [BTB_TAG_W-1:0] stored,
                                           input logic [BTB_TAG_W-1:0] tag);
        return valid && (stored == tag);
    endfunction

endpackage

// File: rtl/branch_target_buffer_way.sv
// One BTB way: valid/tag/target storage, async lookup read, tag probe for training, sync write.
module btb_way
    import lc3b_types::*;
#(
    parameter int unsigned index_bits = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [index_bits-1:0] rd_idx_i,
    output btb_entry_t            rd_entry_o,
    input  logic [index_bits-1:0] probe_idx_i,
    output logic                  probe_valid_o,
    output logic [BTB_TAG_W-1:0]  probe_tag_o,
    input  logic                  we_i,
    input  logic [index_bits-1:0] wr_idx_i,
    input  btb_entry_t            wr_entry_i
);

    localparam int unsigned SETS = 1 << index_bits;

    logic [SETS-1:0]      valid_q;
    logic [BTB_TAG_W-1:0] tag_q    [SETS];
    lc3b_word             target_q [SETS];

    // Valid bits: cleared by reset, set on write.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= wr_entry_i.valid;
        end
    end

    // Tag/target payload needs no reset; reset still blocks the write.
    always_ff @(posedge clk) begin
        if (we_i && !reset) begin
            tag_q[wr_idx_i]    <= wr_entry_i.tag;
            target_q[wr_idx_i] <= wr_entry_i.target;
        end
    end

    // Read ports return pre-write contents (no bypass).
    always_comb begin
        rd_entry_o.valid  = valid_q[rd_idx_i];
        rd_entry_o.tag    = tag_q[rd_idx_i];
        rd_entry_o.target = target_q[rd_idx_i];
        probe_valid_o     = valid_q[probe_idx_i];
        probe_tag_o       = tag_q[probe_idx_i];
    end

endmodule

// File: rtl/branch_target_buffer.sv
// 2-way set-associative BTB: zero-latency lookup, WB-stage training, per-set LRU.
// Define BTB_STATS_EN to add saturating stat_hits / stat_lookups counters.
module branch_target_buffer
    import lc3b_types::*;
#(
    parameter int unsigned index_bits = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  lc3b_word   PC_if,
    input  logic       lookup_en,
    output logic       hit,
    output lc3b_word   predicted_target,
    input  logic       enable,
    input  lc3b_word   PC_wb,
    input  lc3b_opcode opcode_wb,
    input  logic       taken_wb,
    input  lc3b_word   target_wb
`ifdef BTB_STATS_EN
    ,
    output logic [15:0] stat_hits,
    output logic [15:0] stat_lookups
`endif
);

    localparam int unsigned SETS = 1 << index_bits;

    logic [index_bits-1:0] set_if_s, set_wb_s;
    logic [BTB_TAG_W-1:0]  tag_if_s, tag_wb_s;
    btb_entry_t            rd_entry_s [2];
    logic [1:0]            probe_valid_s;
    logic [BTB_TAG_W-1:0]  probe_tag_s [2];
    logic [1:0]            we_s;
    btb_entry_t            wr_entry_s;
    logic                  m0_s, m1_s, hit_way_s;
    logic                  p0_s, p1_s, victim_s, train_s;
    logic [SETS-1:0]       lru_q, lru_d;

    assign set_if_s = PC_if[index_bits:1];
    assign set_wb_s = PC_wb[index_bits:1];
    assign tag_if_s = BTB_TAG_W'(PC_if >> (index_bits + 1));
    assign tag_wb_s = BTB_TAG_W'(PC_wb >> (index_bits + 1));

    for (genvar w = 0; w < 2; w++) begin : g_way
        btb_way #(.index_bits(index_bits)) u_way (
            .clk          (clk),
            .reset        (reset),
            .rd_idx_i     (set_if_s),
            .rd_entry_o   (rd_entry_s[w]),
            .probe_idx_i  (set_wb_s),
            .probe_valid_o(probe_valid_s[w]),
            .probe_tag_o  (probe_tag_s[w]),
            .we_i         (we_s[w]),
            .wr_idx_i     (set_wb_s),
            .wr_entry_i   (wr_entry_s)
        );
    end

    // Lookup hit detect and target mux; way0 wins a (never expected) double match.
    always_comb begin
        m0_s             = btb_tag_match(rd_entry_s[0].valid, rd_entry_s[0].tag, tag_if_s);
        m1_s             = btb_tag_match(rd_entry_s[1].valid, rd_entry_s[1].tag, tag_if_s);
        hit              = m0_s | m1_s;
        hit_way_s        = !m0_s;
        predicted_target = 16'h0000;
        if (m0_s) begin
            predicted_target = rd_entry_s[0].target;
        end else if (m1_s) begin
            predicted_target = rd_entry_s[1].target;
        end else begin
            predicted_target = 16'h0000;
        end
    end

    // Training qualification and victim choice: tag match, then invalid way, then LRU.
    always_comb begin
        train_s  = enable && (opcode_wb == op_br) && taken_wb && !reset;
        p0_s     = btb_tag_match(probe_valid_s[0], probe_tag_s[0], tag_wb_s);
        p1_s     = btb_tag_match(probe_valid_s[1], probe_tag_s[1], tag_wb_s);
        victim_s = 1'b0;
        if (p0_s) begin
            victim_s = 1'b0;
        end else if (p1_s) begin
            victim_s = 1'b1;
        end else if (!probe_valid_s[0]) begin
            victim_s = 1'b0;
        end else if (!probe_valid_s[1]) begin
            victim_s = 1'b1;
        end else begin
            victim_s = lru_q[set_wb_s];
        end
        we_s[0]           = train_s && !victim_s;
        we_s[1]           = train_s && victim_s;
        wr_entry_s.valid  = 1'b1;
        wr_entry_s.tag    = tag_wb_s;
        wr_entry_s.target = target_wb;
    end

    // LRU next state; the training update is applied last so it wins on a shared set.
    always_comb begin
        lru_d = lru_q;
        if (lookup_en && hit) begin
            lru_d[set_if_s] = !hit_way_s;
        end else begin
            lru_d = lru_q;
        end
        if (train_s) begin
            lru_d[set_wb_s] = !victim_s;
        end else begin
            lru_d[set_wb_s] = lru_d[set_wb_s];
        end
    end

    // LRU register.
    always_ff @(posedge clk) begin
        if (reset) begin
            lru_q <= '0;
        end else begin
            lru_q <= lru_d;
        end
    end

`ifdef BTB_STATS_EN
    logic [15:0] stat_hits_q, stat_hits_d, stat_lookups_q, stat_lookups_d;

    // Saturating counter next state.
    always_comb begin
        stat_hits_d    = stat_hits_q;
        stat_lookups_d = stat_lookups_q;
        if (lookup_en && (stat_lookups_q != 16'hFFFF)) begin
            stat_lookups_d = stat_lookups_q + 16'd1;
        end else begin
            stat_lookups_d = stat_lookups_q;
        end
        if (lookup_en && hit && (stat_hits_q != 16'hFFFF)) begin
            stat_hits_d = stat_hits_q + 16'd1;
        end else begin
            stat_hits_d = stat_hits_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_hits_q    <= 16'h0000;
            stat_lookups_q <= 16'h0000;
        end else begin
            stat_hits_q    <= stat_hits_d;
            stat_lookups_q <= stat_lookups_d;
        end
    end

    assign stat_hits    = stat_hits_q;
    assign stat_lookups = stat_lookups_q;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed vector table, then random traffic against a recency-list model.
module tb_branch_target_buffer;
    import lc3b_types::*;

    localparam int SETS = 16;

    logic       clk = 1'b0;
    logic       reset, lookup_en, enable, taken_wb, hit;
    logic [15:0] PC_if, PC_wb, target_wb, predicted_target;
    lc3b_opcode opcode_wb;
`ifdef BTB_STATS_EN
    logic [15:0] stat_hits, stat_lookups;
`endif

    branch_target_buffer #(.index_bits(4)) dut (
        .clk(clk), .reset(reset), .PC_if(PC_if), .lookup_en(lookup_en), .hit(hit),
        .predicted_target(predicted_target), .enable(enable), .PC_wb(PC_wb),
        .opcode_wb(opcode_wb), .taken_wb(taken_wb), .target_wb(target_wb)
`ifdef BTB_STATS_EN
        , .stat_hits(stat_hits), .stat_lookups(stat_lookups)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic rst; logic lk; logic [15:0] pci;
        logic en; logic [15:0] pcw; logic [3:0] op; logic tk; logic [15:0] tg;
        logic eh; logic [15:0] et;
    } vec_t;
    vec_t vt [20];

    // Model: per set, up to two {tag,target} entries, index 0 = most recently used.
    int          mcnt [SETS];
    logic [14:0] mtag [SETS][2];
    logic [15:0] mtgt [SETS][2];
    int          m_lookups, m_hits;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic lk, input logic [15:0] pci, input logic e,
                         input logic [15:0] pcw, input logic [3:0] op, input logic tk, input logic [15:0] tg);
        reset = r; lookup_en = lk; PC_if = pci; enable = e;
        PC_wb = pcw; opcode_wb = lc3b_opcode'(op); taken_wb = tk; target_wb = tg;
    endtask

    function automatic int mfind(input int s, input logic [14:0] t);
        for (int k = 0; k < mcnt[s]; k++) if (mtag[s][k] == t) return k;
        return -1;
    endfunction

    task automatic mfront(input int s, input int k);
        logic [14:0] t; logic [15:0] g;
        if (k == 1) begin
            t = mtag[s][0]; g = mtgt[s][0];
            mtag[s][0] = mtag[s][1]; mtgt[s][0] = mtgt[s][1];
            mtag[s][1] = t; mtgt[s][1] = g;
        end
    endtask

    task automatic mreset();
        for (int s = 0; s < SETS; s++) mcnt[s] = 0;
        m_lookups = 0; m_hits = 0;
    endtask

    initial begin
        int s_if, s_wb, j;
        logic [14:0] t_if, t_wb;
        logic m_hit, trained, r, lk, e, tk;
        logic [15:0] m_tgt, pci, pcw, tg;
        logic [3:0] op;

        vt[0]  = '{0,0,16'h3000, 0,16'h0000,4'd0,0,16'h0000, 0,16'h0000};
        vt[1]  = '{0,1,16'h3000, 1,16'h3000,4'd0,1,16'h3040, 0,16'h0000};
        vt[2]  = '{0,1,16'h3000, 1,16'h3100,4'd0,1,16'h3200, 1,16'h3040};
        vt[3]  = '{0,0,16'h3100, 0,16'h0000,4'd0,0,16'h0000, 1,16'h3200};
        vt[4]  = '{0,1,16'h3000, 0,16'h0000,4'd0,0,16'h0000, 1,16'h3040};
        vt[5]  = '{0,0,16'h3100, 1,16'h3200,4'd0,1,16'h3300, 1,16'h3200};
        vt[6]  = '{0,0,16'h3100, 0,16'h0000,4'd0,0,16'h0000, 0,16'h0000};
        vt[7]  = '{0,0,16'h3000, 0,16'h0000,4'd0,0,16'h0000, 1,16'h3040};
        vt[8]  = '{0,0,16'h3200, 0,16'h0000,4'd0,0,16'h0000, 1,16'h3300};
        vt[9]  = '{0,0,16'h3000, 1,16'h3000,4'd0,1,16'h3080, 1,16'h3040};
        vt[10] = '{0,0,16'h3000, 0,16'h0000,4'd0,0,16'h0000, 1,16'h3080};
        vt[11] = '{0,0,16'h3200, 0,16'h0000,4'd0,0,16'h0000, 1,16'h3300};
        vt[12] = '{0,0,16'h3200, 1,16'h3200,4'd0,0,16'h1234, 1,16'h3300};
        vt[13] = '{0,0,16'h3200, 1,16'h3200,4'd1,1,16'h1234, 1,16'h3300};
        vt[14] = '{0,0,16'h3200, 0,16'h3200,4'd0,1,16'h1234, 1,16'h3300};
        vt[15] = '{0,0,16'h3200, 0,16'h0000,4'd0,0,16'h0000, 1,16'h3300};
        vt[16] = '{1,0,16'h3000, 1,16'h3000,4'd0,1,16'h3ABC, 1,16'h3080};
        vt[17] = '{0,0,16'h3000, 0,16'h0000,4'd0,0,16'h0000, 0,16'h0000};
        vt[18] = '{0,0,16'h3200, 0,16'h0000,4'd0,0,16'h0000, 0,16'h0000};
        vt[19] = '{0,0,16'h3100, 0,16'h0000,4'd0,0,16'h0000, 0,16'h0000};

        drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0, 16'h0000);
        repeat (2) @(posedge clk);

        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            drive(vt[i].rst, vt[i].lk, vt[i].pci, vt[i].en, vt[i].pcw, vt[i].op, vt[i].tk, vt[i].tg);
            @(negedge clk);
            chk($sformatf("vec%0d_hit", i), {15'd0, hit}, {15'd0, vt[i].eh});
            chk($sformatf("vec%0d_target", i), predicted_target, vt[i].et);
        end

`ifdef BTB_STATS_EN
        // 10 lookups, 3 of them hitting.
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 16'h3000, 1'b0, 16'h0000, 4'd0, 1'b0, 16'h0000);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 16'h3000, 1'b1, 16'h3000, 4'd0, 1'b1, 16'h3040);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            drive(1'b0, 1'b1, (i < 3) ? 16'h3000 : 16'h3002, 1'b0, 16'h0000, 4'd0, 1'b0, 16'h0000);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 16'h3000, 1'b0, 16'h0000, 4'd0, 1'b0, 16'h0000);
        @(negedge clk);
        chk("stat_lookups_10", stat_lookups, 16'd10);
        chk("stat_hits_3", stat_hits, 16'd3);
`endif

        // Random phase: few sets and tags so that hits, refreshes and evictions are frequent.
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0, 16'h0000);
        mreset();
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            r   = ($urandom_range(0, 99) < 2);
            lk  = $urandom_range(0, 1);
            e   = ($urandom_range(0, 9) != 0);
            tk  = ($urandom_range(0, 9) < 7);
            op  = ($urandom_range(0, 4) != 0) ? 4'd0 : 4'($urandom_range(0, 15));
            tg  = 16'($urandom);
            pci = 16'((32'h180 + $urandom_range(0, 2)) << 5) | 16'($urandom_range(0, 2) << 1) | 16'($urandom_range(0, 1));
            pcw = 16'((32'h180 + $urandom_range(0, 2)) << 5) | 16'($urandom_range(0, 2) << 1) | 16'($urandom_range(0, 1));
            drive(r, lk, pci, e, pcw, op, tk, tg);
            @(negedge clk);

            s_if = int'(pci[4:1]); t_if = 15'(pci >> 5);
            s_wb = int'(pcw[4:1]); t_wb = 15'(pcw >> 5);
            j = mfind(s_if, t_if);
            m_hit = (j >= 0);
            m_tgt = m_hit ? mtgt[s_if][j] : 16'h0000;
            chk("rand_hit", {15'd0, hit}, {15'd0, m_hit});
            chk("rand_target", predicted_target, m_tgt);

            if (r) begin
                mreset();
            end else begin
                trained = e && (op == 4'd0) && tk;
                if (trained) begin
                    j = mfind(s_wb, t_wb);
                    if (j >= 0) begin
                        mtgt[s_wb][j] = tg;
                        mfront(s_wb, j);
                    end else begin
                        mtag[s_wb][1] = mtag[s_wb][0]; mtgt[s_wb][1] = mtgt[s_wb][0];
                        mtag[s_wb][0] = t_wb;          mtgt[s_wb][0] = tg;
                        if (mcnt[s_wb] < 2) mcnt[s_wb]++;
                    end
                end
                if (lk && m_hit && !(trained && s_if == s_wb)) mfront(s_if, mfind(s_if, t_if));
                if (lk && m_lookups < 65535) m_lookups++;
                if (lk && m_hit && m_hits < 65535) m_hits++;
            end
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0, 16'h0000);
        @(negedge clk);
`ifdef BTB_STATS_EN
        chk("rand_stat_lookups", stat_lookups, 16'(m_lookups));
        chk("rand_stat_hits", stat_hits, 16'(m_hits));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
